// File: rtl/interrupt_dispatch_pkg.sv
// interrupt_dispatch_pkg: state encoding and interrupt control register field layout
package interrupt_dispatch_pkg;
  typedef enum logic [2:0] {S_IDLE, S_DRAIN, S_VECTOR, S_ACK, S_ISR, S_RETURN} state_t;
  localparam int IC_PD_BIT = 15;
  localparam int IC_IR_LSB = 8;
  localparam int IC_EN_LSB = 0;
  localparam int IC_NIRQ = 4;
  localparam logic [31:0] VECTOR_BASE_DEF = 32'h0000_0180;
  localparam int VECTOR_SHIFT_DEF = 4;
endpackage

// File: rtl/interrupt_dispatch_prio_enc.sv
// irq_prio_enc: fixed-priority encoder, highest index wins
module irq_prio_enc (
  input  logic [3:0] req,
  output logic       valid,
  output logic [1:0] id
);
  assign valid = |req;
  assign id = req[3] ? 2'd3 : req[2] ? 2'd2 : req[1] ? 2'd1 : 2'd0;
endmodule

// File: rtl/interrupt_dispatch.sv
// interrupt_dispatch: drains the pipeline, vectors to the winning IRQ, acknowledges it and handles eret
module interrupt_dispatch
  import interrupt_dispatch_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] VECTOR_BASE  = DATA_WIDTH'(VECTOR_BASE_DEF),
  parameter int                    VECTOR_SHIFT = VECTOR_SHIFT_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic [DATA_WIDTH-1:0] i_ic_data,
  output logic                  o_ic_we,
  output logic [DATA_WIDTH-1:0] o_ic_data,
  input  logic [DATA_WIDTH-1:0] i_pc,
  input  logic                  i_pipe_empty,
  input  logic                  i_eret,
  output logic                  o_stall,
  output logic                  o_pc_load,
  output logic [DATA_WIDTH-1:0] o_pc_target,
  output logic [DATA_WIDTH-1:0] o_epc,
  output logic [1:0]            o_irq_id,
  output logic                  o_in_isr
);
  state_t state, next;
  logic [IC_NIRQ-1:0] ir, en;
  logic req_v;
  logic [1:0] req_id;
  logic [15:0] ack_lo, clr;
  logic [DATA_WIDTH-1:0] vec;
  logic unused_ic;
  assign ir = i_ic_data[IC_IR_LSB +: IC_NIRQ];
  assign en = i_ic_data[IC_EN_LSB +: IC_NIRQ];
  assign unused_ic = ^(i_ic_data >> 16);
  irq_prio_enc u_enc (.req(ir & en), .valid(req_v), .id(req_id));
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state <= S_IDLE;
      o_epc <= '0;
      o_irq_id <= '0;
    end else begin
      state <= next;
      if (state == S_DRAIN && req_v && i_pipe_empty) begin
        o_epc <= i_pc;
        o_irq_id <= req_id;
      end
    end
  end
  always_comb begin
    next = state;
    unique case (state)
      S_IDLE:   next = req_v ? S_DRAIN : S_IDLE;
      S_DRAIN:  next = !req_v ? S_IDLE : i_pipe_empty ? S_VECTOR : S_DRAIN;
      S_VECTOR: next = S_ACK;
      S_ACK:    next = S_ISR;
      S_ISR:    next = i_eret ? S_RETURN : S_ISR;
      S_RETURN: next = S_IDLE;
      default:  next = S_IDLE;
    endcase
  end
  // PD survives the acknowledge only while another IR bit is still pending
  always_comb begin
    clr = 16'b1 << (4'(IC_IR_LSB) + {2'b0, o_irq_id});
    ack_lo = i_ic_data[15:0] & ~clr;
    ack_lo[IC_PD_BIT] = ack_lo[IC_PD_BIT] & |ack_lo[IC_IR_LSB +: IC_NIRQ];
  end
  assign vec = VECTOR_BASE + (DATA_WIDTH'(o_irq_id) << VECTOR_SHIFT);
  assign o_stall = state == S_DRAIN || state == S_VECTOR || state == S_ACK;
  assign o_pc_load = state == S_VECTOR || state == S_RETURN;
  assign o_pc_target = state == S_VECTOR ? vec : state == S_RETURN ? o_epc : '0;
  assign o_ic_we = state == S_ACK;
  assign o_ic_data = state == S_ACK ? DATA_WIDTH'(ack_lo) : '0;
  assign o_in_isr = state == S_ISR || state == S_RETURN;
endmodule

// File: tb/tb_interrupt_dispatch.sv
// tb_interrupt_dispatch: directed scoreboard bench for interrupt_dispatch
module tb_interrupt_dispatch;
  logic i_clk = 0, i_nrst = 0, i_pipe_empty = 1, i_eret = 0;
  logic [31:0] i_ic_data = 0, i_pc = 0;
  logic o_ic_we, o_stall, o_pc_load, o_in_isr;
  logic [31:0] o_ic_data, o_pc_target, o_epc;
  logic [1:0] o_irq_id;
  int checks = 0, errors = 0;
  typedef struct {
    logic [31:0] tgt;
    logic [31:0] epc;
    logic [1:0]  id;
    logic [31:0] ack;
  } exp_t;
  exp_t exp_q[$];

  interrupt_dispatch dut (
    .i_clk(i_clk), .i_nrst(i_nrst), .i_ic_data(i_ic_data), .o_ic_we(o_ic_we),
    .o_ic_data(o_ic_data), .i_pc(i_pc), .i_pipe_empty(i_pipe_empty), .i_eret(i_eret),
    .o_stall(o_stall), .o_pc_load(o_pc_load), .o_pc_target(o_pc_target), .o_epc(o_epc),
    .o_irq_id(o_irq_id), .o_in_isr(o_in_isr)
  );

  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_stall"}, 32'(o_stall), 0);
    chk({tag, "_pc_load"}, 32'(o_pc_load), 0);
    chk({tag, "_ic_we"}, 32'(o_ic_we), 0);
    chk({tag, "_in_isr"}, 32'(o_in_isr), 0);
    chk({tag, "_pc_target"}, o_pc_target, 0);
    chk({tag, "_ic_data"}, o_ic_data, 0);
    chk({tag, "_epc"}, o_epc, 0);
    chk({tag, "_irq_id"}, 32'(o_irq_id), 0);
  endtask

  task automatic dispatch();
    exp_t e;
    step();
    chk("drain_stall", 32'(o_stall), 1);
    for (int i = 0; i < 30 && !o_pc_load; i++) step();
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_underflow observed=0 expected=1");
      return;
    end
    e = exp_q.pop_front();
    chk("vec_load", 32'(o_pc_load), 1);
    chk("vec_stall", 32'(o_stall), 1);
    chk("vec_target", o_pc_target, e.tgt);
    chk("vec_epc", o_epc, e.epc);
    chk("vec_id", 32'(o_irq_id), 32'(e.id));
    step();
    chk("ack_we", 32'(o_ic_we), 1);
    chk("ack_stall", 32'(o_stall), 1);
    chk("ack_data", o_ic_data, e.ack);
    i_ic_data = e.ack;
    step();
    chk("isr_flag", 32'(o_in_isr), 1);
    chk("isr_stall", 32'(o_stall), 0);
    chk("isr_we", 32'(o_ic_we), 0);
  endtask

  task automatic eret_ret(input logic [31:0] epc);
    i_eret = 1;
    step();
    i_eret = 0;
    chk("ret_load", 32'(o_pc_load), 1);
    chk("ret_target", o_pc_target, epc);
    chk("ret_in_isr", 32'(o_in_isr), 1);
    chk("ret_stall", 32'(o_stall), 0);
    step();
    chk("idle_in_isr", 32'(o_in_isr), 0);
    chk("idle_pc_load", 32'(o_pc_load), 0);
    chk("idle_stall", 32'(o_stall), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    #2;
    chk_idle_outputs("reset");
    step();
    i_nrst = 1;
    step();
    chk_idle_outputs("post_reset");

    // single IRQ 2
    i_ic_data = 32'h0000_8404;
    i_pc = 32'h400;
    exp_q.push_back('{32'h1A0, 32'h400, 2'd2, 32'h0000_0004});
    dispatch();
    eret_ret(32'h400);

    // priority: IR=1011 EN=1111, then pending lower IRQs drain after each return
    i_ic_data = 32'h0000_8B0F;
    i_pc = 32'h800;
    exp_q.push_back('{32'h1B0, 32'h800, 2'd3, 32'h0000_830F});
    dispatch();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("isr_masked_stall", 32'(o_stall), 0);
      chk("isr_masked_in_isr", 32'(o_in_isr), 1);
    end
    i_pc = 32'h900;
    exp_q.push_back('{32'h190, 32'h900, 2'd1, 32'h0000_810F});
    eret_ret(32'h800);
    dispatch();
    i_pc = 32'hA00;
    exp_q.push_back('{32'h180, 32'hA00, 2'd0, 32'h0000_000F});
    eret_ret(32'h900);
    dispatch();
    eret_ret(32'hA00);
    i_eret = 1;
    step();
    i_eret = 0;
    chk("eret_idle_ignored", 32'(o_pc_load), 0);

    // masking
    i_ic_data = 32'h0000_8100;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("mask_stall", 32'(o_stall), 0);
      chk("mask_load", 32'(o_pc_load), 0);
    end

    // drain then abort
    i_ic_data = 32'h0000_8101;
    i_pipe_empty = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("drain_hold_stall", 32'(o_stall), 1);
      chk("drain_hold_load", 32'(o_pc_load), 0);
    end
    i_ic_data = 32'h0000_8100;
    step();
    chk("abort_stall", 32'(o_stall), 0);
    chk("abort_load", 32'(o_pc_load), 0);
    chk("abort_we", 32'(o_ic_we), 0);
    i_pipe_empty = 1;

    // reset during ACK
    i_ic_data = 32'h0000_8404;
    i_pc = 32'h1234;
    step();
    step();
    step();
    chk("pre_reset_ack_we", 32'(o_ic_we), 1);
    i_nrst = 0;
    #1;
    chk_idle_outputs("mid_ack_reset");
    step();
    i_nrst = 1;
    chk("after_reset_stall", 32'(o_stall), 0);
    step();
    chk("after_reset_drain", 32'(o_stall), 1);
    i_ic_data = 0;
    step();
    chk("after_reset_abort", 32'(o_stall), 0);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
